// File: rtl/mult_iter_pkg.sv
// Shared types and helpers for the iterative multiplier: FSM state encoding,
// digit counts and counter index widths.
package mult_iter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   function automatic int digit_count(input int w, input int dig);
      return w / dig;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_iter_arith.sv
// Datapath for the iterative multiplier: operand magnitudes, digit selection,
// shifted partial-product accumulation and final negation.
// MULT_ITER_SKIP_EN: report the highest nonzero digit of each operand so the
// controller can skip all-zero upper digits.
module mult_iter_arith
   import mult_iter_pkg::*;
#(
   parameter int A_W   = 32,
   parameter int B_W   = 32,
   parameter int A_DIG = 8,
   parameter int B_DIG = 16,
   localparam int NA   = digit_count(A_W, A_DIG),
   localparam int NB   = digit_count(B_W, B_DIG),
   localparam int IA_W = idx_width(NA),
   localparam int IB_W = idx_width(NB)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               negate,
   input  logic               signed_mode,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   input  logic [IA_W-1:0]    i_idx,
   input  logic [IB_W-1:0]    j_idx,
   output logic               neg,
   output logic [IA_W-1:0]    a_last,
   output logic [IB_W-1:0]    b_last,
   output logic [A_W+B_W-1:0] product
);

   localparam int P   = A_W + B_W;
   localparam int PPW = A_DIG + B_DIG;
   localparam int SW  = idx_width(P);

   logic [A_W-1:0]   a_mag, a_mag_reg;
   logic [B_W-1:0]   b_mag, b_mag_reg;
   logic             neg_reg;
   logic [P-1:0]     product_reg;
   logic [A_DIG-1:0] a_digs [NA];
   logic [B_DIG-1:0] b_digs [NB];
   logic [A_DIG-1:0] a_dig;
   logic [B_DIG-1:0] b_dig;
   logic [PPW-1:0]   pp;
   logic [SW-1:0]    shamt;
   logic [P-1:0]     addend;

   // The most-negative value negates to itself, which read unsigned is 2^(W-1).
   assign a_mag = (signed_mode && a[A_W-1]) ? (~a + A_W'(1)) : a;
   assign b_mag = (signed_mode && b[B_W-1]) ? (~b + B_W'(1)) : b;

   genvar gi;
   generate
      for (gi = 0; gi < NA; gi++) begin : g_a_dig
         assign a_digs[gi] = a_mag_reg[gi*A_DIG +: A_DIG];
      end
      for (gi = 0; gi < NB; gi++) begin : g_b_dig
         assign b_digs[gi] = b_mag_reg[gi*B_DIG +: B_DIG];
      end
   endgenerate

   assign a_dig  = a_digs[i_idx];
   assign b_dig  = b_digs[j_idx];
   assign pp     = PPW'(a_dig) * PPW'(b_dig);
   assign shamt  = SW'(i_idx) * SW'(A_DIG) + SW'(j_idx) * SW'(B_DIG);
   assign addend = P'(pp) << shamt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_mag_reg   <= '0;
         b_mag_reg   <= '0;
         neg_reg     <= 1'b0;
         product_reg <= '0;
      end else if (load) begin
         a_mag_reg   <= a_mag;
         b_mag_reg   <= b_mag;
         neg_reg     <= signed_mode & (a[A_W-1] ^ b[B_W-1]);
         product_reg <= '0;
      end else if (step) begin
         product_reg <= product_reg + addend;
      end else if (negate) begin
         product_reg <= -product_reg;
      end
   end

`ifdef MULT_ITER_SKIP_EN
   logic [IA_W-1:0] a_top, a_last_reg;
   logic [IB_W-1:0] b_top, b_last_reg;

   // Highest digit index whose digit or anything above it is nonzero; 0 for zero.
   always_comb begin
      a_top = '0;
      b_top = '0;
      for (int k = 1; k < NA; k++) begin
         if ((a_mag >> (k * A_DIG)) != '0) a_top = IA_W'(k);
      end
      for (int k = 1; k < NB; k++) begin
         if ((b_mag >> (k * B_DIG)) != '0) b_top = IB_W'(k);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_last_reg <= '0;
         b_last_reg <= '0;
      end else if (load) begin
         a_last_reg <= a_top;
         b_last_reg <= b_top;
      end
   end

   assign a_last = a_last_reg;
   assign b_last = b_last_reg;
`else
   assign a_last = IA_W'(NA - 1);
   assign b_last = IB_W'(NB - 1);
`endif

   assign neg     = neg_reg;
   assign product = product_reg;

endmodule

// File: rtl/mult_iter_param.sv
// Iterative A_W x B_W multiplier: control FSM and digit counters driving
// mult_iter_arith. Build with MULT_ITER_SKIP_EN to skip all-zero upper digits.
module mult_iter_param
   import mult_iter_pkg::*;
#(
   parameter int A_W   = 32,
   parameter int B_W   = 32,
   parameter int A_DIG = 8,
   parameter int B_DIG = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic               busy,
   output logic               done,
   output logic [A_W+B_W-1:0] product
);

   localparam int NA   = digit_count(A_W, A_DIG);
   localparam int NB   = digit_count(B_W, B_DIG);
   localparam int IA_W = idx_width(NA);
   localparam int IB_W = idx_width(NB);

   state_t          state_reg, state_next;
   logic [IA_W-1:0] i_reg, i_next, a_last;
   logic [IB_W-1:0] j_reg, j_next, b_last;
   logic            done_reg, done_next;
   logic            load, step, negate, neg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         i_reg     <= '0;
         j_reg     <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         j_reg     <= j_next;
         done_reg  <= done_next;
      end
   end

   // i walks the a digits inside each b digit j.
   always_comb begin
      state_next = state_reg;
      i_next     = i_reg;
      j_next     = j_reg;
      done_next  = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      negate     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               i_next     = '0;
               j_next     = '0;
               state_next = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (i_reg != a_last) begin
               i_next = i_reg + IA_W'(1);
            end else begin
               i_next = '0;
               if (j_reg != b_last) begin
                  j_next = j_reg + IB_W'(1);
               end else begin
                  j_next     = '0;
                  state_next = neg ? FIX : IDLE;
                  done_next  = ~neg;
               end
            end
         end
         FIX: begin
            negate     = 1'b1;
            state_next = IDLE;
            done_next  = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   mult_iter_arith #(
      .A_W   (A_W),
      .B_W   (B_W),
      .A_DIG (A_DIG),
      .B_DIG (B_DIG)
   ) u_arith (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .step        (step),
      .negate      (negate),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .i_idx       (i_reg),
      .j_idx       (j_reg),
      .neg         (neg),
      .a_last      (a_last),
      .b_last      (b_last),
      .product     (product)
   );

   assign busy = (state_reg != IDLE);
   assign done = done_reg;

endmodule
